// File: rtl/shift_issue_stage_pkg.sv
// Shared widths, shifter selector codes and funct encodings for the shift path.
// The execute-stage shifter imports the same selector codes.
package shift_issue_stage_pkg;

    localparam int REG_WIDTH      = 32;
    localparam int SA_WIDTH       = 5;
    localparam int SEL_WIDTH      = 3;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int FUNCT_WIDTH    = 6;

    localparam logic [SEL_WIDTH-1:0] ALU_NOP = 3'b000;
    localparam logic [SEL_WIDTH-1:0] ALU_SLL = 3'b001;
    localparam logic [SEL_WIDTH-1:0] ALU_SRL = 3'b010;
    localparam logic [SEL_WIDTH-1:0] ALU_ROR = 3'b011;
    localparam logic [SEL_WIDTH-1:0] ALU_SRA = 3'b100;
    localparam logic [SEL_WIDTH-1:0] ALU_ROL = 3'b101;

    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL  = 6'b000000;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ROR  = 6'b000001;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL  = 6'b000010;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA  = 6'b000011;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLLV = 6'b000100;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ROL  = 6'b000101;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRLV = 6'b000110;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRAV = 6'b000111;

    typedef struct packed {
        logic [SEL_WIDTH-1:0]      sel;
        logic [SA_WIDTH-1:0]       amount;
        logic [REG_WIDTH-1:0]      data;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      illegal;
    } issue_entry_t;

endpackage

// File: rtl/shift_fwd_mux.sv
// Operand forwarding: EX/MEM over MEM/WB over register file; r0 never forwarded.
// Purely combinational, no backpressure.
module shift_fwd_mux
    import shift_issue_stage_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [REG_WIDTH-1:0]      rf_data,
    input  logic                      exmem_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_WIDTH-1:0]      exmem_data,
    input  logic                      memwb_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [REG_WIDTH-1:0]      memwb_data,
    output logic [REG_WIDTH-1:0]      fwd_data
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_wr_en && (exmem_rd != '0) && (exmem_rd == src_addr);
    assign memwb_hit = memwb_wr_en && (memwb_rd != '0) && (memwb_rd == src_addr);

    always_comb begin
        fwd_data = rf_data;
        if (exmem_hit) begin
            fwd_data = exmem_data;
        end else if (memwb_hit) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// ID/EX register for the shift path: decode + forwarding, 1-cycle latency.
// in_ready drops on stall or when a held entry is not being drained; held outputs stay bit-stable.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FUNCT_WIDTH-1:0]    in_funct,
    input  logic [SA_WIDTH-1:0]       in_shamt,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rt_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [REG_WIDTH-1:0]      in_rs_data,
    input  logic [REG_WIDTH-1:0]      in_rt_data,
    input  logic                      exmem_wr_en,
    input  logic                      memwb_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [REG_WIDTH-1:0]      exmem_data,
    input  logic [REG_WIDTH-1:0]      memwb_data,
    input  logic                      stall,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_WIDTH-1:0]      out_sel_shift,
    output logic [SA_WIDTH-1:0]       out_shift_amount,
    output logic [REG_WIDTH-1:0]      out_data,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_illegal
);

    logic [REG_WIDTH-1:0] rs_fwd;
    logic [REG_WIDTH-1:0] rt_fwd;
    logic                 unused_rs_hi;
    issue_entry_t         dec_entry;
    issue_entry_t         entry_q;
    logic                 valid_q;
    logic                 accept;
    logic                 drain;

    shift_fwd_mux u_rs_fwd (
        .src_addr    (in_rs_addr),
        .rf_data     (in_rs_data),
        .exmem_wr_en (exmem_wr_en),
        .exmem_rd    (exmem_rd),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .fwd_data    (rs_fwd)
    );

    shift_fwd_mux u_rt_fwd (
        .src_addr    (in_rt_addr),
        .rf_data     (in_rt_data),
        .exmem_wr_en (exmem_wr_en),
        .exmem_rd    (exmem_rd),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .fwd_data    (rt_fwd)
    );

    // Variable shifts use rs mod 32, so the upper rs bits are deliberately dropped.
    assign unused_rs_hi = ^rs_fwd[REG_WIDTH-1:SA_WIDTH];

    always_comb begin
        dec_entry         = '0;
        dec_entry.data    = rt_fwd;
        dec_entry.rd_addr = in_rd_addr;
        case (in_funct)
            FUNCT_SLL:  begin dec_entry.sel = ALU_SLL; dec_entry.amount = in_shamt; end
            FUNCT_SRL:  begin dec_entry.sel = ALU_SRL; dec_entry.amount = in_shamt; end
            FUNCT_SRA:  begin dec_entry.sel = ALU_SRA; dec_entry.amount = in_shamt; end
            FUNCT_ROR:  begin dec_entry.sel = ALU_ROR; dec_entry.amount = in_shamt; end
            FUNCT_ROL:  begin dec_entry.sel = ALU_ROL; dec_entry.amount = in_shamt; end
            FUNCT_SLLV: begin dec_entry.sel = ALU_SLL; dec_entry.amount = rs_fwd[SA_WIDTH-1:0]; end
            FUNCT_SRLV: begin dec_entry.sel = ALU_SRL; dec_entry.amount = rs_fwd[SA_WIDTH-1:0]; end
            FUNCT_SRAV: begin dec_entry.sel = ALU_SRA; dec_entry.amount = rs_fwd[SA_WIDTH-1:0]; end
            default: begin
                dec_entry.sel     = ALU_NOP;
                dec_entry.amount  = '0;
                dec_entry.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = ~stall & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign drain    = valid_q & out_ready;

    // Payload is kept on a plain drain so the shifter inputs do not toggle needlessly.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            entry_q <= dec_entry;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid        = valid_q;
    assign out_sel_shift    = entry_q.sel;
    assign out_shift_amount = entry_q.amount;
    assign out_data         = entry_q.data;
    assign out_rd_addr      = entry_q.rd_addr;
    assign out_illegal      = entry_q.illegal;

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

ID/EX pipeline register for the shift path of the lab8 pipelined core. Decodes the shift funct field, resolves operand forwarding from EX/MEM and MEM/WB, and selects the immediate or register shift amount. Registers the selector, amount, data word and destination for the execute-stage shifter. Supports stall, flush and a valid/ready handshake so the shifter always sees a stable, fully resolved operation.

## Interface
- REG_WIDTH, 32, data word width
- SA_WIDTH, 5, shift-amount width
- SEL_WIDTH, 3, shifter selector width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid / in_ready  in / out  1  decode-side handshake
- in_funct  in  6  instruction funct field
- in_shamt  in  SA_WIDTH  instruction shamt field
- in_rs_addr, in_rt_addr, in_rd_addr  in  5  register addresses
- in_rs_data, in_rt_data  in  REG_WIDTH  register-file read data
- exmem_wr_en, memwb_wr_en  in  1  writeback enables of the later stages
- exmem_rd, memwb_rd  in  5  destination addresses of the later stages
- exmem_data, memwb_data  in  REG_WIDTH  results of the later stages
- stall  in  1  hazard-unit hold
- flush  in  1  branch/exception kill
- out_valid / out_ready  out / in  1  execute-side handshake
- out_sel_shift  out  SEL_WIDTH  shifter selector
- out_shift_amount  out  SA_WIDTH  shifter amount
- out_data  out  REG_WIDTH  word to shift
- out_rd_addr  out  5  destination register
- out_illegal  out  1  unrecognised funct

## Operation
- Decode, funct to sel/amount source:
  - 000000 SLL: sel 001, amount shamt.
  - 000010 SRL: sel 010, amount shamt.
  - 000011 SRA: sel 100, amount shamt.
  - 000001 ROR: sel 011, amount shamt.
  - 000101 ROL: sel 101, amount shamt.
  - 000100 SLLV: sel 001, amount rs[4:0].
  - 000110 SRLV: sel 010, amount rs[4:0].
  - 000111 SRAV: sel 100, amount rs[4:0].
  - Any other funct: sel 000, amount 0, illegal=1.
- Data word is always forwarded rt; rs is used only for the variable-amount forms.
- Forwarding, per operand:
  - EX/MEM wins when wr_en=1, rd≠0 and rd equals the source address.
  - Otherwise MEM/WB under the same conditions.
  - Otherwise register-file data.
  - Address 0 is never forwarded.
- Register states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - Capture when in_valid & in_ready.
  - Drain when out_valid & out_ready.
  - Capture and drain in the same cycle: stays FULL with the new entry.
- in_ready = ~stall & (~out_valid | out_ready).

## Timing
- Latency 1 cycle: input accepted at edge N appears on outputs after edge N.
- Reset, and flush: out_valid=0, out_sel_shift=0, out_shift_amount=0, out_data=0, out_rd_addr=0, out_illegal=0.
- Reset mid-operation discards the held entry.
- Priority: rst_n low > flush > stall > normal.
- flush together with in_valid: the incoming entry is also dropped.
- stall: in_ready=0, register holds, outputs stable.
  - A FULL entry still drains if out_ready=1, then becomes EMPTY.
- FULL and out_ready=0: all outputs held bit-stable; no capture.
- Forwarding is combinational on the input side, using exmem/memwb values from the accept cycle only.
- Amount is SA_WIDTH bits; rs bits above SA_WIDTH-1 are ignored (shift by rs mod 32).

## Structure
- Shared defines file holds REG_WIDTH, SA_WIDTH, SEL_WIDTH, the ALU_SLL/SRL/ROR/SRA/ROL selector codes, and the funct constants.
- The shifter consumes the same selector codes, so they are never duplicated.
- One sub-module `shift_fwd_mux`: address compare plus 3:1 select, instantiated once per operand (rs, rt).
- Decode and the pipeline register live in the top module.

## Test plan
- SLL, shamt=4, rt_data=0x0000_00F1, no hazards → next cycle out_valid=1, sel=001, amount=4, data=0x0000_00F1, illegal=0.
- SRAV, rs_data=0x0000_0123, rt_data=0x8000_0000, exmem_rd=rt_addr=5 with exmem_data=0xF000_000F, memwb_rd=5 → data=0xF000_000F (EX/MEM wins), amount=3, sel=100.
- SLLV, rs_addr=0, exmem_rd=0, exmem_wr_en=1, exmem_data=7, rs_data=2 → amount=2 (no forwarding from r0).
- funct=001000 → sel=000, amount=0, illegal=1, out_valid=1.
- FULL with out_ready=0 for 3 cycles and new in_valid → in_ready=0, outputs unchanged. Then out_ready=1 with in_valid → new entry visible next cycle with no bubble.
- flush asserted with in_valid=1 while FULL → next cycle out_valid=0, all outputs 0. rst_n=0 mid-stream → same values on the next edge.
